// File: rtl/act_pkg.sv
// rtl/act_pkg.sv - shared constants and types for the C2 select consumer stage
package act_pkg;

   localparam int XLEN_DEF = 8;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   localparam logic [1:0] SEL_00 = 2'b00;
   localparam logic [1:0] SEL_01 = 2'b01;
   localparam logic [1:0] SEL_10 = 2'b10;
   localparam logic [1:0] SEL_11 = 2'b11;

endpackage

// File: rtl/act_c2_sel.sv
// rtl/act_c2_sel.sv - combinational C2 selection: S1 = A1|B1, S0 = A0&B0, 4:1 word pick
module act_c2_sel
   import act_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] i_d00,
   input  logic [XLEN-1:0] i_d01,
   input  logic [XLEN-1:0] i_d10,
   input  logic [XLEN-1:0] i_d11,
   input  logic            i_a1,
   input  logic            i_b1,
   input  logic            i_a0,
   input  logic            i_b0,
   output logic [XLEN-1:0] o_data
);

   logic [1:0] w_code;

   assign w_code = {i_a1 | i_b1, i_a0 & i_b0};

   always_comb begin
      o_data = i_d00;
      case (w_code)
         SEL_00:  o_data = i_d00;
         SEL_01:  o_data = i_d01;
         SEL_10:  o_data = i_d10;
         SEL_11:  o_data = i_d11;
         default: o_data = i_d00;
      endcase
   end

endmodule

// File: rtl/act_c2_reg_stage.sv
// rtl/act_c2_reg_stage.sv - registered C2 consumer with 2-entry skid buffer; ACT_C2_REG_STAGE_CLR_EN adds clr flush
module act_c2_reg_stage
   import act_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef ACT_C2_REG_STAGE_CLR_EN
   input  logic             clr,
`endif
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  D00,
   input  logic [XLEN-1:0]  D01,
   input  logic [XLEN-1:0]  D10,
   input  logic [XLEN-1:0]  D11,
   input  logic             A1,
   input  logic             B1,
   input  logic             A0,
   input  logic             B0,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_data,
   output logic [CNT_W-1:0] out_cnt
);

   state_t            r_state;
   state_t            w_next;
   logic              r_in_ready;
   logic [XLEN-1:0]   r_head;
   logic [XLEN-1:0]   r_skid;
   logic [CNT_W-1:0]  r_cnt;
   logic [XLEN-1:0]   w_sel;
   logic              w_in_xfer;
   logic              w_out_xfer;
   logic              w_clr;

`ifdef ACT_C2_REG_STAGE_CLR_EN
   assign w_clr = clr;
`else
   assign w_clr = 1'b0;
`endif

   act_c2_sel #(.XLEN(XLEN)) u_sel (
      .i_d00  (D00),
      .i_d01  (D01),
      .i_d10  (D10),
      .i_d11  (D11),
      .i_a1   (A1),
      .i_b1   (B1),
      .i_a0   (A0),
      .i_b0   (B0),
      .o_data (w_sel)
   );

   assign w_in_xfer  = in_valid & r_in_ready;
   assign w_out_xfer = out_valid & out_ready;

   always_comb begin
      w_next = r_state;
      case (r_state)
         EMPTY: if (w_in_xfer) w_next = ONE;
         ONE: begin
            if (w_in_xfer && !w_out_xfer)      w_next = TWO;
            else if (!w_in_xfer && w_out_xfer) w_next = EMPTY;
         end
         TWO:     if (w_out_xfer) w_next = ONE;
         default: w_next = EMPTY;
      endcase
      if (w_clr) w_next = EMPTY;
   end

   // in_ready is registered from the next state so it never depends on inputs combinationally
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= EMPTY;
         r_in_ready <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_in_ready <= (w_next != TWO);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_head <= '0;
         r_skid <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_out_xfer) r_cnt <= r_cnt + CNT_W'(1);
         if (w_clr) begin
            r_head <= '0;
            r_skid <= '0;
         end else begin
            case (r_state)
               EMPTY: if (w_in_xfer) r_head <= w_sel;
               ONE: begin
                  if (w_in_xfer && w_out_xfer) r_head <= w_sel;
                  else if (w_in_xfer)          r_skid <= w_sel;
               end
               TWO:     if (w_out_xfer) r_head <= r_skid;
               default: ;
            endcase
         end
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = (r_state != EMPTY);
   assign out_data  = r_head;
   assign out_cnt   = r_cnt;

endmodule

// File: tb/tb_act_c2_reg_stage.sv
// tb/tb_act_c2_reg_stage.sv - directed self-checking bench for act_c2_reg_stage
module tb_act_c2_reg_stage;

   localparam int XLEN  = 8;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clr;
   logic             in_valid;
   logic             in_ready;
   logic [XLEN-1:0]  D00, D01, D10, D11;
   logic             A1, B1, A0, B0;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_data;
   logic [CNT_W-1:0] out_cnt;

   int total = 0;
   int bad   = 0;

   logic [7:0] sweep_exp [16] = '{8'h11, 8'h11, 8'h11, 8'h22,
                                  8'h33, 8'h33, 8'h33, 8'h44,
                                  8'h33, 8'h33, 8'h33, 8'h44,
                                  8'h33, 8'h33, 8'h33, 8'h44};

   always #5 clk = ~clk;

   act_c2_reg_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef ACT_C2_REG_STAGE_CLR_EN
      .clr       (clr),
`endif
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .D00       (D00),
      .D01       (D01),
      .D10       (D10),
      .D11       (D11),
      .A1        (A1),
      .B1        (B1),
      .A0        (A0),
      .B0        (B0),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_cnt   (out_cnt)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      D00 = 8'h11; D01 = 8'h22; D10 = 8'h33; D11 = 8'h44;
      A1 = 1'b0; B1 = 1'b0; A0 = 1'b0; B0 = 1'b0;

      // reset
      step(); step();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'h00);
      chk("rst_out_cnt", 32'(out_cnt), 32'd0);
      rst_n = 1'b1;
      step();
      chk("rel_in_ready", 32'(in_ready), 32'd1);

      // single beat selecting D01
      A0 = 1'b1; B0 = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("s1_valid", 32'(out_valid), 32'd1);
      chk("s1_data", 32'(out_data), 32'h22);
      step();
      chk("s1_cnt", 32'(out_cnt), 32'd1);
      chk("s1_empty", 32'(out_valid), 32'd0);

      // select sweep, streaming with out_ready held high
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         {A1, B1, A0, B0} = 4'(i);
         step();
         chk($sformatf("sweep_%0d", i), 32'(out_data), 32'(sweep_exp[i]));
      end
      in_valid = 1'b0;
      step();
      chk("sweep_cnt", 32'(out_cnt), 32'd17);
      chk("sweep_empty", 32'(out_valid), 32'd0);

      // back-pressure
      {A1, B1, A0, B0} = 4'b0000;
      out_ready = 1'b0; in_valid = 1'b1; D00 = 8'h01;
      step();
      chk("bp_rdy1", 32'(in_ready), 32'd1);
      D00 = 8'h02;
      step();
      chk("bp_rdy2", 32'(in_ready), 32'd0);
      chk("bp_head2", 32'(out_data), 32'h01);
      D00 = 8'h03;
      step();
      chk("bp_hold_rdy", 32'(in_ready), 32'd0);
      chk("bp_hold_data", 32'(out_data), 32'h01);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      step();
      chk("bp_drain2", 32'(out_data), 32'h02);
      chk("bp_rdy_back", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("bp_drain3", 32'(out_data), 32'h03);
      step();
      chk("bp_empty", 32'(out_valid), 32'd0);
      chk("bp_cnt", 32'(out_cnt), 32'd20);

      // simultaneous transfers in ONE
      in_valid = 1'b1; D00 = 8'h50;
      step();
      for (int k = 1; k <= 10; k++) begin
         D00 = 8'(8'h50 + k);
         step();
         chk($sformatf("both_data_%0d", k), 32'(out_data), 32'(8'h50 + k));
         chk($sformatf("both_rdy_%0d", k), 32'(in_ready), 32'd1);
      end
      in_valid = 1'b0;
      chk("both_cnt", 32'(out_cnt), 32'd30);
      step();
      chk("both_cnt_drain", 32'(out_cnt), 32'd31);
      chk("both_empty", 32'(out_valid), 32'd0);

      // counter wrap
      rst_n = 1'b0;
      step();
      chk("wrap_rst_cnt", 32'(out_cnt), 32'd0);
      rst_n = 1'b1;
      step();
      in_valid = 1'b1; D00 = 8'h00;
      step();
      for (int k = 1; k <= 255; k++) begin
         D00 = 8'(k);
         step();
      end
      chk("wrap_cnt_255", 32'(out_cnt), 32'd255);
      chk("wrap_last_data", 32'(out_data), 32'hFF);
      in_valid = 1'b0;
      step();
      chk("wrap_cnt_0", 32'(out_cnt), 32'd0);

      // reset while holding two words
      out_ready = 1'b0; in_valid = 1'b1; D00 = 8'hA1;
      step();
      D00 = 8'hA2;
      step();
      in_valid = 1'b0;
      chk("mid_full", 32'(in_ready), 32'd0);
      rst_n = 1'b0; out_ready = 1'b1;
      step();
      chk("mid_valid", 32'(out_valid), 32'd0);
      chk("mid_cnt", 32'(out_cnt), 32'd0);
      chk("mid_data", 32'(out_data), 32'h00);
      rst_n = 1'b1;
      step();
      chk("mid_rdy", 32'(in_ready), 32'd1);
      chk("mid_no_stale", 32'(out_valid), 32'd0);

`ifdef ACT_C2_REG_STAGE_CLR_EN
      // flush while full; output transfer in the flush cycle is still counted
      out_ready = 1'b0; in_valid = 1'b1; D00 = 8'hB1;
      step();
      D00 = 8'hB2;
      step();
      in_valid = 1'b0;
      chk("clr_full", 32'(in_ready), 32'd0);
      clr = 1'b1; out_ready = 1'b1;
      step();
      clr = 1'b0;
      chk("clr_valid", 32'(out_valid), 32'd0);
      chk("clr_cnt", 32'(out_cnt), 32'd1);
      chk("clr_rdy", 32'(in_ready), 32'd1);
      chk("clr_data", 32'(out_data), 32'h00);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
